// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, redirect flush, operand forwarding selects
// and saturating stall/flush event counters.
module hazard_controller #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_write_reg_addr,
    input  logic             ex_reg_write,
    input  logic             ex_is_load,
    input  logic [4:0]       mem_write_reg_addr,
    input  logic             mem_reg_write,
    input  logic             redirect_valid,
    output logic [1:0]       fa_mux_op,
    output logic [1:0]       fb_mux_op,
    output logic             stall_pc_op,
    output logic             stall_if_id_op,
    output logic             bubble_ex_op,
    output logic             flush_if_id_op,
    output logic             flush_id_ex_op,
    output logic [CNT_W-1:0] stall_count_op,
    output logic [CNT_W-1:0] flush_count_op
);

    // Forward mux codes
    localparam logic [1:0] NO_FORWARD_SELECT = 2'b00;
    localparam logic [1:0] EX_RESULT_SELECT  = 2'b01;
    localparam logic [1:0] MEM_RESULT_SELECT = 2'b10;

    // The redirect cycle itself is the first flush cycle; the counter covers the rest.
    localparam logic [2:0] FLUSH_RELOAD    = 3'(FLUSH_CYCLES - 1);
    localparam logic       ONE_CYCLE_FLUSH = (FLUSH_CYCLES == 1);

    typedef enum logic [1:0] {StRun, StLoadStall, StFlush} state_t;

    state_t           state_q, state_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic [1:0]       fa_q, fb_q;
    logic [1:0]       fa_sel, fb_sel;
    logic [CNT_W-1:0] stall_count_q, flush_count_q;
    logic             load_use;

    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                           input logic ex_wr, input logic [4:0] ex_rd,
                                           input logic mem_wr, input logic [4:0] mem_rd);
        logic [1:0] sel;
        sel = NO_FORWARD_SELECT;
        if (used && rs != 5'd0) begin
            if (ex_wr && ex_rd == rs) begin
                sel = EX_RESULT_SELECT;
            end else if (mem_wr && mem_rd == rs) begin
                sel = MEM_RESULT_SELECT;
            end
        end
        return sel;
    endfunction

    // Hazard detection and forward select computation from the ID instruction
    always_comb begin
        load_use = id_valid && ex_is_load && ex_reg_write && (ex_write_reg_addr != 5'd0) &&
                   ((id_rs1_used && id_rs1_addr == ex_write_reg_addr) ||
                    (id_rs2_used && id_rs2_addr == ex_write_reg_addr));
        fa_sel = fwd_sel(id_rs1_used, id_rs1_addr, ex_reg_write, ex_write_reg_addr,
                         mem_reg_write, mem_write_reg_addr);
        fb_sel = fwd_sel(id_rs2_used, id_rs2_addr, ex_reg_write, ex_write_reg_addr,
                         mem_reg_write, mem_write_reg_addr);
    end

    // Next-state and control outputs; redirect always wins over load-use
    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        stall_pc_op    = 1'b0;
        stall_if_id_op = 1'b0;
        bubble_ex_op   = 1'b0;
        flush_if_id_op = 1'b0;
        flush_id_ex_op = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StRun, StLoadStall: begin
                    if (redirect_valid) begin
                        state_d        = ONE_CYCLE_FLUSH ? StRun : StFlush;
                        flush_cnt_d    = FLUSH_RELOAD;
                        flush_if_id_op = 1'b1;
                        flush_id_ex_op = 1'b1;
                    end else if (state_q == StRun && load_use) begin
                        state_d        = StLoadStall;
                        stall_pc_op    = 1'b1;
                        stall_if_id_op = 1'b1;
                        bubble_ex_op   = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
                StFlush: begin
                    flush_if_id_op = 1'b1;
                    flush_id_ex_op = 1'b1;
                    if (redirect_valid) begin
                        flush_cnt_d = FLUSH_RELOAD;
                    end else begin
                        flush_cnt_d = (flush_cnt_q != 3'd0) ? flush_cnt_q - 3'd1 : 3'd0;
                        if (flush_cnt_q <= 3'd1) begin
                            state_d = StRun;
                        end
                    end
                end
                default: begin
                    state_d     = StRun;
                    flush_cnt_d = 3'd0;
                end
            endcase
        end
    end

    // State, flush counter, registered forward selects and saturating event counters
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StRun;
            flush_cnt_q   <= 3'd0;
            fa_q          <= NO_FORWARD_SELECT;
            fb_q          <= NO_FORWARD_SELECT;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            if (bubble_ex_op || flush_id_ex_op || !id_valid) begin
                fa_q <= NO_FORWARD_SELECT;
                fb_q <= NO_FORWARD_SELECT;
            end else if (!stall_if_id_op) begin
                fa_q <= fa_sel;
                fb_q <= fb_sel;
            end
            if (bubble_ex_op && stall_count_q != '1) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
            if (redirect_valid && flush_count_q != '1) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
        end
    end

    assign fa_mux_op      = fa_q;
    assign fb_mux_op      = fb_q;
    assign stall_count_op = stall_count_q;
    assign flush_count_op = flush_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (FLUSH_CYCLES=2, CNT_W=4).
module tb_hazard_controller;

    localparam logic [1:0] NOF = 2'b00;
    localparam logic [1:0] EXS = 2'b01;
    localparam logic [1:0] MEMS = 2'b10;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1_addr, id_rs2_addr;
    logic       id_rs1_used, id_rs2_used;
    logic [4:0] ex_write_reg_addr;
    logic       ex_reg_write, ex_is_load;
    logic [4:0] mem_write_reg_addr;
    logic       mem_reg_write;
    logic       redirect_valid;
    logic [1:0] fa_mux_op, fb_mux_op;
    logic       stall_pc_op, stall_if_id_op, bubble_ex_op, flush_if_id_op, flush_id_ex_op;
    logic [3:0] stall_count_op, flush_count_op;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_controller #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_write_reg_addr(ex_write_reg_addr), .ex_reg_write(ex_reg_write),
        .ex_is_load(ex_is_load), .mem_write_reg_addr(mem_write_reg_addr),
        .mem_reg_write(mem_reg_write), .redirect_valid(redirect_valid),
        .fa_mux_op(fa_mux_op), .fb_mux_op(fb_mux_op),
        .stall_pc_op(stall_pc_op), .stall_if_id_op(stall_if_id_op),
        .bubble_ex_op(bubble_ex_op), .flush_if_id_op(flush_if_id_op),
        .flush_id_ex_op(flush_id_ex_op), .stall_count_op(stall_count_op),
        .flush_count_op(flush_count_op)
    );

    always #5 clock = ~clock;

    // Inputs change 1 time unit after the rising edge; checks occur 1 unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_write_reg_addr = 5'd0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
        mem_write_reg_addr = 5'd0; mem_reg_write = 1'b0; redirect_valid = 1'b0;
    endtask

    // EX holds lw x5; ID holds add x6,x5,x1
    task automatic load_use_inputs();
        id_valid = 1'b1; id_rs1_addr = 5'd5; id_rs2_addr = 5'd1;
        id_rs1_used = 1'b1; id_rs2_used = 1'b1;
        ex_write_reg_addr = 5'd5; ex_reg_write = 1'b1; ex_is_load = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        load_use_inputs();
        redirect_valid = 1'b1;
        #1;
        n_cmp++;
        if ({stall_pc_op, stall_if_id_op, bubble_ex_op, flush_if_id_op, flush_id_ex_op} !== 5'b0)
        begin
            n_bad++;
            $display("FAIL reset_ctrl_low: got %b want 00000",
                     {stall_pc_op, stall_if_id_op, bubble_ex_op, flush_if_id_op, flush_id_ex_op});
        end
        tick();
        #1;
        n_cmp++;
        if ({fa_mux_op, fb_mux_op, stall_count_op, flush_count_op} !== {NOF, NOF, 4'd0, 4'd0})
        begin
            n_bad++;
            $display("FAIL reset_regs: got fa=%0d fb=%0d sc=%0d fc=%0d want 0 0 0 0",
                     fa_mux_op, fb_mux_op, stall_count_op, flush_count_op);
        end
        idle_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        load_use_inputs();
        #1;
        n_cmp++;
        if ({stall_pc_op, stall_if_id_op, bubble_ex_op, flush_if_id_op} !== 4'b1110) begin
            n_bad++;
            $display("FAIL lu_stall: got %b want 1110",
                     {stall_pc_op, stall_if_id_op, bubble_ex_op, flush_if_id_op});
        end
        tick();
        n_cmp++;
        if (stall_count_op !== 4'd1 || fa_mux_op !== NOF) begin
            n_bad++;
            $display("FAIL lu_count: got sc=%0d fa=%0d want sc=1 fa=0", stall_count_op, fa_mux_op);
        end
        // Bubble now in EX, lw moved to MEM, add re-evaluated in ID
        ex_write_reg_addr = 5'd0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
        mem_write_reg_addr = 5'd5; mem_reg_write = 1'b1;
        #1;
        n_cmp++;
        if ({stall_pc_op, stall_if_id_op, bubble_ex_op} !== 3'b000) begin
            n_bad++;
            $display("FAIL lu_one_cycle: got %b want 000", {stall_pc_op, stall_if_id_op, bubble_ex_op});
        end
        tick();
        n_cmp++;
        if (fa_mux_op !== MEMS || fb_mux_op !== NOF || stall_count_op !== 4'd1) begin
            n_bad++;
            $display("FAIL lu_mem_fwd: got fa=%0d fb=%0d sc=%0d want fa=2 fb=0 sc=1",
                     fa_mux_op, fb_mux_op, stall_count_op);
        end
    endtask

    task automatic test_double_forward();
        do_reset();
        id_valid = 1'b1; id_rs1_addr = 5'd3; id_rs2_addr = 5'd3;
        id_rs1_used = 1'b1; id_rs2_used = 1'b1;
        ex_write_reg_addr = 5'd3; ex_reg_write = 1'b1;
        mem_write_reg_addr = 5'd3; mem_reg_write = 1'b1;
        tick();
        n_cmp++;
        if (fa_mux_op !== EXS || fb_mux_op !== EXS) begin
            n_bad++;
            $display("FAIL dbl_ex_priority: got fa=%0d fb=%0d want 1 1", fa_mux_op, fb_mux_op);
        end
        // x0 is never forwarded, even with both stages writing x0
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
        ex_write_reg_addr = 5'd0; mem_write_reg_addr = 5'd0;
        tick();
        n_cmp++;
        if (fa_mux_op !== NOF || fb_mux_op !== NOF) begin
            n_bad++;
            $display("FAIL x0_no_fwd: got fa=%0d fb=%0d want 0 0", fa_mux_op, fb_mux_op);
        end
        // MEM-only match on rs2, unused rs1 matching EX
        id_rs1_addr = 5'd7; id_rs1_used = 1'b0; ex_write_reg_addr = 5'd7;
        id_rs2_addr = 5'd9; mem_write_reg_addr = 5'd9;
        tick();
        n_cmp++;
        if (fa_mux_op !== NOF || fb_mux_op !== MEMS) begin
            n_bad++;
            $display("FAIL mem_fwd_b: got fa=%0d fb=%0d want 0 2", fa_mux_op, fb_mux_op);
        end
        // Invalid ID instruction registers non-forwarding
        id_valid = 1'b0;
        tick();
        n_cmp++;
        if (fb_mux_op !== NOF) begin
            n_bad++;
            $display("FAIL invalid_id: got fb=%0d want 0", fb_mux_op);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        redirect_valid = 1'b1;
        #1;
        n_cmp++;
        if ({flush_if_id_op, flush_id_ex_op} !== 2'b11) begin
            n_bad++;
            $display("FAIL redir_c1: got %b want 11", {flush_if_id_op, flush_id_ex_op});
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if ({flush_if_id_op, flush_id_ex_op} !== 2'b11 || flush_count_op !== 4'd1) begin
            n_bad++;
            $display("FAIL redir_c2: got %b fc=%0d want 11 fc=1",
                     {flush_if_id_op, flush_id_ex_op}, flush_count_op);
        end
        tick();
        n_cmp++;
        if ({flush_if_id_op, flush_id_ex_op} !== 2'b00 || flush_count_op !== 4'd1) begin
            n_bad++;
            $display("FAIL redir_end: got %b fc=%0d want 00 fc=1",
                     {flush_if_id_op, flush_id_ex_op}, flush_count_op);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        load_use_inputs();
        redirect_valid = 1'b1;
        #1;
        n_cmp++;
        if ({stall_pc_op, stall_if_id_op, bubble_ex_op, flush_if_id_op, flush_id_ex_op} !== 5'b00011)
        begin
            n_bad++;
            $display("FAIL sim_flush_only: got %b want 00011",
                     {stall_pc_op, stall_if_id_op, bubble_ex_op, flush_if_id_op, flush_id_ex_op});
        end
        tick();
        idle_inputs();
        redirect_valid = 1'b1;  // second redirect in flush cycle 2
        #1;
        n_cmp++;
        if (stall_count_op !== 4'd0 || flush_count_op !== 4'd1 || flush_if_id_op !== 1'b1) begin
            n_bad++;
            $display("FAIL sim_counts: got sc=%0d fc=%0d fl=%b want 0 1 1",
                     stall_count_op, flush_count_op, flush_if_id_op);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if ({flush_if_id_op, flush_id_ex_op} !== 2'b11) begin
            n_bad++;
            $display("FAIL sim_extend_c3: got %b want 11", {flush_if_id_op, flush_id_ex_op});
        end
        tick();
        n_cmp++;
        if ({flush_if_id_op, flush_id_ex_op} !== 2'b00 || flush_count_op !== 4'd2) begin
            n_bad++;
            $display("FAIL sim_extend_end: got %b fc=%0d want 00 fc=2",
                     {flush_if_id_op, flush_id_ex_op}, flush_count_op);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        redirect_valid = 1'b1;
        #1;
        reset = 1'b1;  // reset during flush cycle 1
        #1;
        n_cmp++;
        if ({flush_if_id_op, flush_id_ex_op} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_flush_comb: got %b want 00", {flush_if_id_op, flush_id_ex_op});
        end
        tick();
        reset = 1'b0;
        redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if ({flush_if_id_op, flush_id_ex_op, stall_pc_op} !== 3'b000 ||
            flush_count_op !== 4'd0 || stall_count_op !== 4'd0 || fa_mux_op !== NOF) begin
            n_bad++;
            $display("FAIL rst_flush_after: got fl=%b sc=%0d fc=%0d fa=%0d want 000 0 0 0",
                     {flush_if_id_op, flush_id_ex_op, stall_pc_op}, stall_count_op,
                     flush_count_op, fa_mux_op);
        end
        // Reset while in LOAD_STALL, then a fresh hazard must stall again at once
        load_use_inputs();
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_use_inputs();
        #1;
        n_cmp++;
        if ({stall_pc_op, bubble_ex_op} !== 2'b11 || stall_count_op !== 4'd0) begin
            n_bad++;
            $display("FAIL rst_stall_after: got st=%b sc=%0d want 11 0",
                     {stall_pc_op, bubble_ex_op}, stall_count_op);
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        load_use_inputs();
        // Held hazard: stall cycle then LOAD_STALL cycle, one count per two cycles
        for (int i = 0; i < 28; i++) tick();
        n_cmp++;
        if (stall_count_op !== 4'd14) begin
            n_bad++;
            $display("FAIL sat_14: got %0d want 14", stall_count_op);
        end
        for (int i = 0; i < 12; i++) tick();
        n_cmp++;
        if (stall_count_op !== 4'd15) begin
            n_bad++;
            $display("FAIL sat_15: got %0d want 15", stall_count_op);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_double_forward();
        test_redirect();
        test_simultaneous();
        test_reset_mid_op();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
